host_img_reader: RTL and testbench
==================================

Name: host_img_reader

Overview:
- Host-to-FPGA read engine for the edge-detect AFU; the input-side counterpart of the existing result write-back path.
- On start, issues CCI-P c0 read requests for N consecutive cache lines from a host buffer.
- Unpacks each returned 512-bit line into 16 32-bit pixels and writes them into the edge-detect input pixel memory.
- Pulses done once every pixel has been written, which the AFU FSM uses as the go condition for edge_detect_top.

Parameters:
MAX_OUTSTANDING, 8, max read lines in flight (power of 2, 2..64); also response FIFO depth
PIX_AW, 19, pixel-memory address width
LINE_AW, 15, line-count width (max 2^15-1 lines = 524272 pixels)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; latches base_addr/num_lines when idle
base_addr  in  42  host cache-line address of line 0
num_lines  in  LINE_AW  lines to read
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse on completion
c0tx_valid  out  1  read request valid (registered)
c0tx_addr  out  42  request cache-line address
c0tx_mdata  out  16  request tag = line index [LINE_AW-1:0], zero-extended
c0tx_almfull  in  1  c0 request channel almost full
c0rx_valid  in  1  read response valid (cannot be back-pressured)
c0rx_data  in  512  response line
c0rx_mdata  in  16  response tag
pix_wr_en  out  1  pixel memory write strobe
pix_wr_addr  out  PIX_AW  pixel address
pix_wr_data  out  24  pixel RGB = bits [23:0] of the 32-bit lane; bits [31:24] discarded

Behaviour:
- Reset values: busy=0, done=0, c0tx_valid=0, pix_wr_en=0, addresses 0, state IDLE, credits=MAX_OUTSTANDING, FIFO empty.
- FSM: IDLE -> REQ -> DRAIN -> FIN -> IDLE.
- IDLE:
  - start latches base_addr, num_lines; clears req_idx and lines_done; busy=1.
  - num_lines==0 goes straight to FIN.
  - start while busy is ignored.
- REQ: each cycle with !c0tx_almfull and credits>0 and req_idx<num_lines:
  - next cycle c0tx_valid=1, c0tx_addr=base_addr+req_idx, c0tx_mdata=req_idx.
  - req_idx++, credits--.
  - Go to DRAIN when req_idx==num_lines.
- Responses:
  - Every c0rx_valid is pushed into rsp_fifo as {mdata, data}, in any state except IDLE.
  - Responses arriving in IDLE are dropped.
  - Responses may arrive out of order. Pixel address comes from the tag, not arrival order, so no reordering is done.
- Unpack:
  - When the FIFO is non-empty, emit lane k=0..15 over 16 consecutive cycles.
  - pix_wr_addr = {tag,4'b0}+k, truncated to PIX_AW; pix_wr_data = data[32k+23:32k].
  - Pixel write latency is 1 cycle after FIFO head is valid; back-to-back lines are unpacked with no bubble.
  - On lane 15: pop FIFO, lines_done++, credits++.
  - Simultaneous credit return and request issue in the same cycle leaves credits unchanged.
- FIFO overflow is impossible by construction: credits bound in-flight plus buffered lines to MAX_OUTSTANDING. An assertion flags push-when-full.
- DRAIN: wait until lines_done==num_lines (implies FIFO empty, credits full) -> FIN.
- FIN: done=1 for exactly one cycle, busy=0 the same cycle -> IDLE.
- Reset mid-operation: all state returns to reset values within one cycle. Late responses from the aborted run then land in IDLE and are dropped.
- Widths:
  - Address add is 42-bit modular; wrap is legal and not flagged.
  - Pixel address truncation above 2^PIX_AW is the software's responsibility.

Decomposition:
- Package host_img_reader_pkg holds:
  - PIX_PER_LINE=16 and PIX_LANE_W=32
  - t_state enum
  - t_rsp_entry struct {tag, data}
- One sub-module, img_rsp_fifo: synchronous FIFO, DEPTH=MAX_OUTSTANDING, width 16+512, first-word-fall-through, full/empty flags.
- Everything else lives in the top module.

Test Plan:
- num_lines=1, base_addr=0x1000, pixel lane k=k+1 -> one request (addr 0x1000, mdata 0); 16 writes at addr 0..15 with data 1..16; done one cycle after the last write.
- num_lines=0 -> no c0tx_valid; done pulses 2 cycles after start; busy high exactly 1 cycle.
- num_lines=20, MAX_OUTSTANDING=8, responses withheld -> exactly 8 requests, then stall. Releasing responses resumes issue; all 320 pixels written; done once.
- num_lines=4, responses returned in tag order 3,1,0,2 -> writes land at addresses 48-63, 16-31, 0-15, 32-47 with correct data.
- c0tx_almfull held high for 10 cycles mid-run -> no requests during that window; request count and data otherwise unchanged.
- reset asserted after 3 of 10 lines are requested, then a stray response arrives -> outputs at reset values, no pix_wr_en; a new start with num_lines=2 completes normally.

Source files
------------

// File: rtl/host_img_reader_pkg.sv
// Shared types and constants for the host image read engine.
package host_img_reader_pkg;

  localparam int unsigned CL_ADDR_W    = 42;
  localparam int unsigned TAG_W        = 16;
  localparam int unsigned LINE_W       = 512;
  localparam int unsigned PIX_PER_LINE = 16;
  localparam int unsigned PIX_LANE_W   = 32;
  localparam int unsigned PIX_W        = 24;
  localparam int unsigned LANE_IDX_W   = $clog2(PIX_PER_LINE);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    FIN
  } t_state;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } t_rsp_entry;

  localparam int unsigned RSP_ENTRY_W = $bits(t_rsp_entry);

  // RGB part of one 32-bit lane; the top byte of each lane is not used.
  function automatic logic [PIX_W-1:0] lane_pixel(input logic [LINE_W-1:0]     line,
                                                  input logic [LANE_IDX_W-1:0] k);
    return line[PIX_LANE_W*k +: PIX_W];
  endfunction

endpackage

// File: rtl/img_rsp_fifo.sv
// Show-ahead response FIFO: the head entry is readable while the FIFO is not empty.
module img_rsp_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 528
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata_c,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata_c = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/host_img_reader.sv
// Reads N host cache lines over CCI-P c0 and scatters their pixels into the
// edge-detect input memory, addressing each line by its returned tag.
module host_img_reader
  import host_img_reader_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned PIX_AW          = 19,
  parameter int unsigned LINE_AW         = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [41:0]          base_addr,
  input  logic [LINE_AW-1:0]   num_lines,
  output logic                 busy,
  output logic                 done,
  output logic                 c0tx_valid,
  output logic [41:0]          c0tx_addr,
  output logic [15:0]          c0tx_mdata,
  input  logic                 c0tx_almfull,
  input  logic                 c0rx_valid,
  input  logic [511:0]         c0rx_data,
  input  logic [15:0]          c0rx_mdata,
  output logic                 pix_wr_en,
  output logic [PIX_AW-1:0]    pix_wr_addr,
  output logic [23:0]          pix_wr_data
);

  localparam int unsigned CRED_W = $clog2(MAX_OUTSTANDING) + 1;

  t_state                 state;
  t_state                 state_nxt;
  logic [CL_ADDR_W-1:0]   base_q;
  logic [LINE_AW-1:0]     num_q;
  logic [LINE_AW-1:0]     req_idx;
  logic [LINE_AW-1:0]     lines_done;
  logic [LINE_AW-1:0]     lines_done_nxt;
  logic [CRED_W-1:0]      credits;
  logic [LANE_IDX_W-1:0]  lane;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   accept;
  t_rsp_entry             rsp_in;
  t_rsp_entry             head;
  logic [RSP_ENTRY_W-1:0] head_raw;

  assign accept         = (state == IDLE) && start;
  assign push           = c0rx_valid && (state != IDLE);
  assign rsp_in         = '{tag: c0rx_mdata, data: c0rx_data};
  assign head           = t_rsp_entry'(head_raw);
  assign pop            = !fifo_empty && (lane == LANE_IDX_W'(PIX_PER_LINE - 1));
  assign lines_done_nxt = lines_done + LINE_AW'(pop);

  img_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (RSP_ENTRY_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wdata   (rsp_in),
    .pop     (pop),
    .rdata_c (head_raw),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Leave DRAIN on the same edge as the final pop so done follows the last write by one cycle.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_lines == '0) ? FIN : REQ;
      end
      REQ: begin
        issue = !c0tx_almfull && (credits != '0) && (req_idx < num_q);
        if (issue && ((req_idx + LINE_AW'(1)) == num_q)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (lines_done_nxt == num_q) state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job control, request issue and credit accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q     <= '0;
      num_q      <= '0;
      req_idx    <= '0;
      lines_done <= '0;
      credits    <= CRED_W'(MAX_OUTSTANDING);
      busy       <= 1'b0;
      done       <= 1'b0;
      c0tx_valid <= 1'b0;
      c0tx_addr  <= '0;
      c0tx_mdata <= '0;
    end else begin
      c0tx_valid <= issue;
      done       <= (state == FIN);
      if (state == FIN) busy <= 1'b0;

      if (issue) begin
        c0tx_addr  <= CL_ADDR_W'(base_q + CL_ADDR_W'(req_idx));
        c0tx_mdata <= TAG_W'(req_idx);
      end

      case ({issue, pop})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01:   credits <= credits + CRED_W'(1);
        default: credits <= credits;
      endcase

      if (accept) begin
        base_q     <= base_addr;
        num_q      <= num_lines;
        req_idx    <= '0;
        lines_done <= '0;
        busy       <= 1'b1;
      end else begin
        if (issue) req_idx <= req_idx + LINE_AW'(1);
        lines_done <= lines_done_nxt;
      end
    end
  end

  // One lane per cycle from the FIFO head; the tag alone decides where the line lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane        <= '0;
      pix_wr_en   <= 1'b0;
      pix_wr_addr <= '0;
      pix_wr_data <= '0;
    end else begin
      pix_wr_en <= !fifo_empty;
      if (!fifo_empty) begin
        pix_wr_addr <= PIX_AW'({head.tag, lane});
        pix_wr_data <= lane_pixel(head.data, lane);
        lane        <= lane + LANE_IDX_W'(1);
      end
    end
  end

  // Credits cap in-flight plus buffered lines at the FIFO depth.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_host_img_reader.sv
// Self-checking bench for host_img_reader: host memory model, randomised responder,
// request/pixel scoreboard, directed corner cases and a table of jobs.
module tb_host_img_reader;
  import host_img_reader_pkg::*;

  localparam int unsigned MAXO    = 8;
  localparam int unsigned PIX_AW  = 19;
  localparam int unsigned LINE_AW = 15;

  logic               clk;
  logic               reset;
  logic               start;
  logic [41:0]        base_addr;
  logic [LINE_AW-1:0] num_lines;
  logic               busy;
  logic               done;
  logic               c0tx_valid;
  logic [41:0]        c0tx_addr;
  logic [15:0]        c0tx_mdata;
  logic               c0tx_almfull;
  logic               c0rx_valid;
  logic [511:0]       c0rx_data;
  logic [15:0]        c0rx_mdata;
  logic               pix_wr_en;
  logic [PIX_AW-1:0]  pix_wr_addr;
  logic [23:0]        pix_wr_data;

  host_img_reader #(
    .MAX_OUTSTANDING (MAXO),
    .PIX_AW          (PIX_AW),
    .LINE_AW         (LINE_AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .num_lines    (num_lines),
    .busy         (busy),
    .done         (done),
    .c0tx_valid   (c0tx_valid),
    .c0tx_addr    (c0tx_addr),
    .c0tx_mdata   (c0tx_mdata),
    .c0tx_almfull (c0tx_almfull),
    .c0rx_valid   (c0rx_valid),
    .c0rx_data    (c0rx_data),
    .c0rx_mdata   (c0rx_mdata),
    .pix_wr_en    (pix_wr_en),
    .pix_wr_addr  (pix_wr_addr),
    .pix_wr_data  (pix_wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Host memory: every cache line has deterministic content derived from its address.
  bit seq_data = 1'b0;

  function automatic logic [31:0] lane_word(input logic [41:0] a, input int k);
    logic [31:0] h;
    if (seq_data) return 32'(k + 1);
    h = (a[31:0] * 32'h9E3779B1) + (32'(k) * 32'h01000193);
    h = h ^ {10'h0, a[41:32], 12'h0};
    return h;
  endfunction

  function automatic logic [511:0] line_data(input logic [41:0] a);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = lane_word(a, k);
    return l;
  endfunction

  // Scoreboard state for the current job.
  typedef struct {
    int          tag;
    logic [41:0] addr;
  } pend_t;

  logic [41:0] cur_base;
  int          cur_n;
  int          req_cnt, pix_cnt, lines_seen, done_cnt, busy_cyc, done_cyc, last_pix_cyc, start_cyc;
  bit          written [int];
  int          wr_log [$];
  pend_t       pending [$];
  bit          almfull_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (c0tx_valid) begin
        chk("req_tag_order", c0tx_mdata, req_cnt);
        chk("req_addr", c0tx_addr, 42'(cur_base + 42'(c0tx_mdata)));
        chk("req_in_range", c0tx_mdata < cur_n, 1);
        chk("req_credit_bound", (req_cnt + 1) <= (MAXO + lines_seen), 1);
        chk("req_during_almfull", almfull_prev, 0);
        pending.push_back('{tag: int'(c0tx_mdata), addr: c0tx_addr});
        req_cnt++;
      end
      if (pix_wr_en) begin
        int          line;
        int          k;
        logic [31:0] w;
        line = int'(pix_wr_addr >> 4);
        k    = int'(pix_wr_addr[3:0]);
        w    = lane_word(42'(cur_base + 42'(line)), k);
        chk("pix_in_range", line < cur_n, 1);
        chk("pix_duplicate", written.exists(int'(pix_wr_addr)), 0);
        chk("pix_data", pix_wr_data, w[23:0]);
        written[int'(pix_wr_addr)] = 1'b1;
        wr_log.push_back(int'(pix_wr_addr));
        pix_cnt++;
        last_pix_cyc = cyc;
        if (k == 15) lines_seen++;
      end
      if (busy) busy_cyc++;
      if (done) begin
        chk("busy_low_with_done", busy, 0);
        done_cnt++;
        done_cyc = cyc;
      end
      almfull_prev = c0tx_almfull;
    end
  end

  // Host responder: returns pending lines in random order, or in a forced tag order.
  bit rsp_en = 1'b1;
  bit hold   = 1'b0;
  int order_q [$];

  initial begin
    c0rx_valid = 1'b0;
    c0rx_data  = '0;
    c0rx_mdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rsp_en) begin
        int idx;
        idx = -1;
        c0rx_valid = 1'b0;
        if (!hold && pending.size() > 0) begin
          if (order_q.size() > 0) begin
            foreach (pending[i]) if (pending[i].tag == order_q[0]) idx = i;
            if (idx >= 0) void'(order_q.pop_front());
          end else if ($urandom_range(0, 3) != 0) begin
            idx = int'($urandom_range(0, pending.size() - 1));
          end
        end
        if (idx >= 0) begin
          c0rx_valid = 1'b1;
          c0rx_mdata = 16'(pending[idx].tag);
          c0rx_data  = line_data(pending[idx].addr);
          pending.delete(idx);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_run(input logic [41:0] b, input int n);
    cur_base   = b;
    cur_n      = n;
    req_cnt    = 0;
    pix_cnt    = 0;
    lines_seen = 0;
    done_cnt   = 0;
    busy_cyc   = 0;
    done_cyc   = -1;
    written.delete();
    wr_log.delete();
  endtask

  task automatic do_start(input logic [41:0] b, input int n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    num_lines = LINE_AW'(n);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int t;
    t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(name, done_cnt > 0, 1);
  endtask

  typedef struct {
    logic [41:0] base;
    int          n;
    int          exp_req;
    int          exp_pix;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];
  int   ord [4];

  initial begin
    vecs[0] = '{42'h000_0001_0000, 3,  3,  48,  1};
    vecs[1] = '{42'h3FF_FFFF_FFFE, 5,  5,  80,  1};
    vecs[2] = '{42'h123_4567_89AB, 8,  8,  128, 1};
    vecs[3] = '{42'h000_0000_0000, 9,  9,  144, 1};
    vecs[4] = '{42'h000_0000_0ABC, 17, 17, 272, 1};
    vecs[5] = '{42'h000_0000_0001, 1,  1,  16,  1};
    ord     = '{3, 1, 0, 2};

    reset        = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    num_lines    = '0;
    c0tx_almfull = 1'b0;
    clear_run(42'h0, 0);
    tick(3);
    reset = 1'b0;

    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_c0tx_valid", c0tx_valid, 0);
    chk("rst_pix_wr_en", pix_wr_en, 0);
    chk("rst_c0tx_addr", c0tx_addr, 0);
    chk("rst_c0tx_mdata", c0tx_mdata, 0);
    chk("rst_pix_wr_addr", pix_wr_addr, 0);
    tick(1);

    // Single line with lane k holding k+1.
    seq_data = 1'b1;
    clear_run(42'h1000, 1);
    do_start(42'h1000, 1);
    wait_done("one_line_done", 300);
    chk("one_line_reqs", req_cnt, 1);
    chk("one_line_pix", pix_cnt, 16);
    if (wr_log.size() == 16)
      for (int k = 0; k < 16; k++) chk("one_line_addr_seq", wr_log[k], k);
    chk("one_line_done_latency", done_cyc, last_pix_cyc + 1);
    tick(5);
    seq_data = 1'b0;

    // Empty job.
    clear_run(42'h55, 0);
    do_start(42'h55, 0);
    wait_done("zero_done", 20);
    tick(3);
    chk("zero_reqs", req_cnt, 0);
    chk("zero_done_cycle", done_cyc, start_cyc + 2);
    chk("zero_busy_cycles", busy_cyc, 1);
    chk("zero_done_count", done_cnt, 1);

    // Credit stall with responses withheld, plus an ignored start while busy.
    hold = 1'b1;
    clear_run(42'h2_0000, 20);
    do_start(42'h2_0000, 20);
    tick(40);
    chk("stall_reqs", req_cnt, MAXO);
    chk("stall_busy", busy, 1);
    start     = 1'b1;
    base_addr = 42'h999;
    num_lines = LINE_AW'(3);
    tick(1);
    start = 1'b0;
    tick(5);
    hold = 1'b0;
    wait_done("stall_done", 3000);
    tick(10);
    chk("stall_reqs_total", req_cnt, 20);
    chk("stall_pix_total", pix_cnt, 320);
    chk("stall_done_count", done_cnt, 1);

    // Out-of-order return 3,1,0,2.
    foreach (ord[i]) order_q.push_back(ord[i]);
    clear_run(42'h7000, 4);
    do_start(42'h7000, 4);
    wait_done("ooo_done", 500);
    tick(5);
    chk("ooo_pix", pix_cnt, 64);
    if (wr_log.size() == 64)
      for (int j = 0; j < 64; j++) chk("ooo_write_order", wr_log[j], ord[j/16]*16 + j%16);
    order_q.delete();

    // Almost-full window mid-run.
    clear_run(42'h3_0000, 30);
    do_start(42'h3_0000, 30);
    tick(4);
    c0tx_almfull = 1'b1;
    tick(10);
    c0tx_almfull = 1'b0;
    wait_done("almfull_done", 3000);
    tick(5);
    chk("almfull_reqs", req_cnt, 30);
    chk("almfull_pix", pix_cnt, 480);

    // Reset mid-job, then a stray late response.
    hold = 1'b1;
    clear_run(42'h4_0000, 10);
    do_start(42'h4_0000, 10);
    begin
      int t;
      t = 0;
      while (req_cnt < 3 && t < 50) begin
        tick(1);
        t++;
      end
      chk("abort_reqs_seen", req_cnt >= 3, 1);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_c0tx_valid", c0tx_valid, 0);
    chk("abort_pix_wr_en", pix_wr_en, 0);
    chk("abort_c0tx_addr", c0tx_addr, 0);
    chk("abort_pix_wr_addr", pix_wr_addr, 0);
    tick(1);
    pending.delete();
    clear_run(42'h0, 0);
    rsp_en     = 1'b0;
    c0rx_valid = 1'b1;
    c0rx_mdata = 16'd1;
    c0rx_data  = line_data(42'h4_0001);
    tick(1);
    c0rx_valid = 1'b0;
    tick(20);
    chk("stray_pix", pix_cnt, 0);
    chk("stray_reqs", req_cnt, 0);
    chk("stray_busy", busy, 0);
    rsp_en = 1'b1;
    hold   = 1'b0;
    clear_run(42'h5_0000, 2);
    do_start(42'h5_0000, 2);
    wait_done("after_abort_done", 500);
    tick(5);
    chk("after_abort_reqs", req_cnt, 2);
    chk("after_abort_pix", pix_cnt, 32);

    // Table of jobs.
    for (int v = 0; v < 6; v++) begin
      clear_run(vecs[v].base, vecs[v].n);
      do_start(vecs[v].base, vecs[v].n);
      wait_done("vec_done", 3000);
      tick(5);
      chk("vec_reqs", req_cnt, vecs[v].exp_req);
      chk("vec_pix", pix_cnt, vecs[v].exp_pix);
      chk("vec_done_count", done_cnt, vecs[v].exp_done);
    end

    // Random jobs.
    for (int r = 0; r < 6; r++) begin
      logic [63:0] rb;
      int          n;
      rb = {$urandom(), $urandom()};
      n  = int'($urandom_range(1, 40));
      clear_run(rb[41:0], n);
      do_start(rb[41:0], n);
      wait_done("rand_done", 4000);
      tick(5);
      chk("rand_reqs", req_cnt, n);
      chk("rand_pix", pix_cnt, 16 * n);
      chk("rand_done_count", done_cnt, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
